multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Multi-cycle sequencer for the RV32 core: steps one instruction at a time through FETCH, DECODE, EXEC, MEM and WB. It drives the write enables for the instruction register, PC and regfile. It handshakes with instruction and data memory, and keeps retired-instruction and cycle counters. It sits beside the datapath and gates when the write-back stage's pc_new and data2reg are committed.

Parameters:
CNT_W, 32, width of instret and cycle counters
MEM_TIMEOUT, 16, max wait cycles for imem/dmem ack before bus error; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
opcode  in  7  opcode field of the current IR (IR[6:0])
imem_req  out  1  instruction fetch request, held until ack
imem_ack  in  1  fetch data valid this cycle
dmem_req  out  1  data access request, held until ack
dmem_we  out  1  data access is a store (valid with dmem_req)
dmem_ack  in  1  data access complete this cycle
ir_we  out  1  latch instruction into IR
pc_we  out  1  commit pc_new to PC
reg_we  out  1  commit data2reg to rd
ren  out  1  write-back select: memory data (loads)
state  out  3  current state encoding
retire  out  1  one-cycle pulse per retired instruction
halted  out  1  sticky: SYSTEM opcode reached
err  out  1  sticky error flag
err_code  out  2  00 none, 01 illegal opcode, 10 imem timeout, 11 dmem timeout
instret  out  CNT_W  retired instruction count
cycles  out  CNT_W  active-cycle count

Behaviour:
- Reset (async): state=IDLE. All outputs, counters, err_code, latched class and wait counter are 0. Reset mid-operation aborts any pending request immediately.
- IDLE: all strobes 0. Goes to FETCH on the next edge.
- FETCH: imem_req=1. When imem_ack=1: ir_we=1 in the same cycle, next state DECODE.
- DECODE (1 cycle): classify opcode and latch the class.
  - LOAD 0000011, STORE 0100011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111, AUIPC 0010111, OP-IMM 0010011 and OP 0110011 go to EXEC.
  - SYSTEM 1110011 goes to HALT.
  - Any other opcode goes to ERR with err_code=01.
- EXEC (1 cycle): LOAD/STORE go to MEM; all other classes go to WB.
- MEM: dmem_req=1; dmem_we=1 iff STORE; ren=1 iff LOAD. When dmem_ack=1, go to WB.
- WB (1 cycle):
  - pc_we=1 and retire=1.
  - reg_we=1 except for STORE and BRANCH.
  - ren=1 iff LOAD.
  - instret increments; next state FETCH.
- HALT / ERR: terminal until reset. All strobes 0. halted/err=1. Counters frozen.
- Timeout: the wait counter clears on entry to FETCH and to MEM, and increments each cycle the ack is low.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT with ack still low, go to ERR with err_code 10 (FETCH) or 11 (MEM). The request drops the next cycle.
  - An ack arriving in the same cycle the counter reaches MEM_TIMEOUT wins: normal transition, no error.
- Acks outside FETCH/MEM, or imem_ack during MEM, are ignored.
- cycles increments every cycle not in IDLE, HALT or ERR. Both counters wrap from 2^CNT_W-1 to 0 silently.
- Latency, zero-wait memory:
  - ALU/branch/jump/U-type: 4 cycles (F, D, E, W).
  - load/store: 5 cycles (F, D, E, M, W).
- Strobes are combinational from state plus ack. The state register and counters are the only flops besides the latched class and err_code.

Decomposition:
- Package rv32_ctrl_pkg: state encodings (IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7), opcode constants, err_code constants, instruction-class enum.
- Sub-module opcode_classifier: combinational, opcode to class + illegal flag.

Test Plan:
- Reset release, opcode=0110011, imem_ack=1 on first FETCH cycle: state sequence 0,1,2,3,5,1. reg_we=1 and pc_we=1 only in WB. instret=1 after 5 cycles from reset release.
- LOAD 0000011, dmem_ack after 3 wait cycles: dmem_req high 4 cycles, dmem_we=0, ren=1 in MEM and WB, reg_we=1. STORE 0100011: dmem_we=1, reg_we=0 in WB.
- BRANCH 1100011: WB has pc_we=1, reg_we=0, retire=1. Opcode 0000000: ERR with err_code=01. Stays there 10 cycles with all strobes 0 and instret unchanged.
- MEM_TIMEOUT=4, imem_ack held 0: ERR with err_code=10 after 4 FETCH cycles. Separate run with ack on the 4th wait cycle: proceeds to DECODE, no error.
- rst asserted mid-MEM with dmem_req=1: dmem_req, state and counters go to 0 asynchronously. After release: IDLE then FETCH.
- CNT_W=4, 16 retired ALU instructions: instret wraps to 0. SYSTEM 1110011: halted=1 and cycles frozen.

Source files
------------

// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32 multi-cycle control sequencer:
// state numbering, opcode constants, error codes and instruction classes.
package rv32_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_IMEM    = 2'b10,
        ERR_DMEM    = 2'b11
    } err_code_t;

    typedef enum logic [3:0] {
        CLS_NONE,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_JAL,
        CLS_JALR,
        CLS_LUI,
        CLS_AUIPC,
        CLS_OPIMM,
        CLS_OP,
        CLS_SYSTEM
    } instr_class_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    function automatic logic is_mem(input instr_class_t c);
        return (c == CLS_LOAD) || (c == CLS_STORE);
    endfunction

endpackage

// File: rtl/opcode_classifier.sv
// Combinational RV32 opcode decode: maps IR[6:0] to an instruction class
// and flags anything outside the supported base opcodes as illegal.
module opcode_classifier
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t cls,
    output logic         illegal
);

    always_comb begin
        cls     = CLS_NONE;
        illegal = 1'b0;
        unique case (opcode)
            OP_LOAD:   cls = CLS_LOAD;
            OP_STORE:  cls = CLS_STORE;
            OP_BRANCH: cls = CLS_BRANCH;
            OP_JAL:    cls = CLS_JAL;
            OP_JALR:   cls = CLS_JALR;
            OP_LUI:    cls = CLS_LUI;
            OP_AUIPC:  cls = CLS_AUIPC;
            OP_OPIMM:  cls = CLS_OPIMM;
            OP_OP:     cls = CLS_OP;
            OP_SYSTEM: cls = CLS_SYSTEM;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// handshakes, bus timeouts, sticky halt/error and retire/cycle counters.
module multicycle_ctrl
    import rv32_ctrl_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             ir_we,
    output logic             pc_we,
    output logic             reg_we,
    output logic             ren,
    output logic [2:0]       state,
    output logic             retire,
    output logic             halted,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] instret,
    output logic [CNT_W-1:0] cycles
);

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t       state_q, state_d;
    instr_class_t cls_q, cls_dec;
    err_code_t    err_code_q, err_val;
    logic         illegal;
    logic         wait_last;
    logic         waiting;
    logic         active;
    logic [WAIT_W-1:0] wait_q;
    logic [CNT_W-1:0]  instret_q, cycles_q;

    opcode_classifier u_cls (
        .opcode  (opcode),
        .cls     (cls_dec),
        .illegal (illegal)
    );

    // Ack in the same cycle as the final wait slot still wins.
    assign wait_last = (MEM_TIMEOUT > 0) &&
                       (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

    assign waiting = ((state_q == S_FETCH) && !imem_ack) ||
                     ((state_q == S_MEM) && !dmem_ack);

    assign active = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                    (state_q == S_EXEC) || (state_q == S_MEM) ||
                    (state_q == S_WB);

    always_comb begin
        state_d  = state_q;
        err_val  = ERR_NONE;
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ren      = 1'b0;
        pc_we    = 1'b0;
        reg_we   = 1'b0;
        retire   = 1'b0;
        unique case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_last) begin
                    state_d = S_ERR;
                    err_val = ERR_IMEM;
                end
            end
            S_DECODE: begin
                if (illegal) begin
                    state_d = S_ERR;
                    err_val = ERR_ILLEGAL;
                end else if (cls_dec == CLS_SYSTEM) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: state_d = is_mem(cls_q) ? S_MEM : S_WB;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == CLS_STORE);
                ren      = (cls_q == CLS_LOAD);
                if (dmem_ack) begin
                    state_d = S_WB;
                end else if (wait_last) begin
                    state_d = S_ERR;
                    err_val = ERR_DMEM;
                end
            end
            S_WB: begin
                pc_we   = 1'b1;
                retire  = 1'b1;
                reg_we  = (cls_q != CLS_STORE) && (cls_q != CLS_BRANCH);
                ren     = (cls_q == CLS_LOAD);
                state_d = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            S_ERR:  state_d = S_ERR;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cls_q      <= CLS_NONE;
            err_code_q <= ERR_NONE;
            wait_q     <= '0;
            instret_q  <= '0;
            cycles_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                cls_q <= cls_dec;
            end
            if (err_val != ERR_NONE) begin
                err_code_q <= err_val;
            end
            // Cleared everywhere else, so it starts at 0 on FETCH/MEM entry.
            if (waiting) begin
                wait_q <= wait_q + WAIT_W'(1);
            end else begin
                wait_q <= '0;
            end
            if (active) begin
                cycles_q <= cycles_q + CNT_W'(1);
            end
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    assign state    = state_q;
    assign halted   = (state_q == S_HALT);
    assign err      = (state_q == S_ERR);
    assign err_code = err_code_q;
    assign instret  = instret_q;
    assign cycles   = cycles_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected traces built from
// opcode class and memory wait counts, checked every cycle on negedge.
module tb_multicycle_ctrl;

    localparam int CW = 4;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [6:0]    opcode = 7'h00;
    logic          imem_ack = 1'b0;
    logic          dmem_ack = 1'b0;
    logic          imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, ren;
    logic [2:0]    state;
    logic          retire, halted, err;
    logic [1:0]    err_code;
    logic [CW-1:0] instret, cycles;

    always #5 clk = ~clk;

    multicycle_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .opcode   (opcode),
        .imem_req (imem_req),
        .imem_ack (imem_ack),
        .dmem_req (dmem_req),
        .dmem_we  (dmem_we),
        .dmem_ack (dmem_ack),
        .ir_we    (ir_we),
        .pc_we    (pc_we),
        .reg_we   (reg_we),
        .ren      (ren),
        .state    (state),
        .retire   (retire),
        .halted   (halted),
        .err      (err),
        .err_code (err_code),
        .instret  (instret),
        .cycles   (cycles)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int abort_at = -1;
    logic chk_en = 1'b0;

    logic [2:0]    e_state = 3'd0;
    logic [7:0]    e_sb = 8'h00;
    logic [1:0]    e_code = 2'b00;
    logic [CW-1:0] e_instret = '0;
    logic [CW-1:0] e_cycles = '0;

    logic [CW-1:0] instret_m = '0;
    logic [CW-1:0] cycles_m = '0;
    logic [1:0]    code_m = 2'b00;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t=%0t got %0h want %0h", name, $time, act, exp);
        end
    endtask

    // Sorts opcodes: 0 plain retire, 1 load, 2 store, 3 branch, 4 system, 5 illegal
    function automatic int kind(input logic [6:0] op);
        case (op)
            7'b0000011: return 1;
            7'b0100011: return 2;
            7'b1100011: return 3;
            7'b1101111, 7'b1100111, 7'b0110111,
            7'b0010111, 7'b0010011, 7'b0110011: return 0;
            7'b1110011: return 4;
            default: return 5;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("state", 32'(state), 32'(e_state));
            check("imem_req", 32'(imem_req), 32'(e_sb[7]));
            check("ir_we", 32'(ir_we), 32'(e_sb[6]));
            check("dmem_req", 32'(dmem_req), 32'(e_sb[5]));
            check("dmem_we", 32'(dmem_we), 32'(e_sb[4]));
            check("ren", 32'(ren), 32'(e_sb[3]));
            check("pc_we", 32'(pc_we), 32'(e_sb[2]));
            check("reg_we", 32'(reg_we), 32'(e_sb[1]));
            check("retire", 32'(retire), 32'(e_sb[0]));
            check("halted", 32'(halted), 32'(e_state == 3'd6));
            check("err", 32'(err), 32'(e_state == 3'd7));
            check("err_code", 32'(err_code), 32'(e_code));
            check("instret", 32'(instret), 32'(e_instret));
            check("cycles", 32'(cycles), 32'(e_cycles));
        end
    end

    // strobe vector: ireq irwe dreq dwe ren pwe rwe retire
    task automatic cyc(input logic [2:0] st, input logic [7:0] sb,
                       input logic ia, input logic da);
        imem_ack  = ia;
        dmem_ack  = da;
        e_state   = st;
        e_sb      = sb;
        e_code    = code_m;
        e_instret = instret_m;
        e_cycles  = cycles_m;
        chk_en    = 1'b1;
        @(posedge clk);
        #1;
        if (st >= 3'd1 && st <= 3'd5) cycles_m = cycles_m + CW'(1);
        if (sb[0]) instret_m = instret_m + CW'(1);
    endtask

    task automatic hold(input int n, input logic [2:0] st);
        for (int i = 0; i < n; i++) begin
            cyc(st, 8'h00, (i % 2) == 1, (i % 2) == 0);
        end
    endtask

    task automatic do_reset();
        chk_en    = 1'b0;
        rst       = 1'b1;
        imem_ack  = 1'b0;
        dmem_ack  = 1'b0;
        instret_m = '0;
        cycles_m  = '0;
        code_m    = 2'b00;
        @(posedge clk);
        #1;
        cyc(3'd0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(3'd0, 8'h00, 1'b0, 1'b0);
    endtask

    // Stray acks are driven outside their owning state to show they are ignored.
    task automatic instr(input logic [6:0] op, input int iw, input int dw);
        int k;
        logic ld, st, br;
        k  = kind(op);
        ld = (k == 1);
        st = (k == 2);
        br = (k == 3);
        opcode = op;
        for (int i = 0; i <= iw; i++) begin
            if (i == TO) begin
                code_m = 2'b10;
                return;
            end
            cyc(3'd1, {1'b1, i == iw, 6'b000000}, i == iw, 1'b1);
        end
        cyc(3'd2, 8'h00, 1'b1, 1'b1);
        opcode = 7'h7f;
        if (k == 4) return;
        if (k == 5) begin
            code_m = 2'b01;
            return;
        end
        cyc(3'd3, 8'h00, 1'b1, 1'b1);
        if (ld || st) begin
            for (int i = 0; i <= dw; i++) begin
                if (i == abort_at) return;
                if (i == TO) begin
                    code_m = 2'b11;
                    return;
                end
                cyc(3'd4, {3'b001, st, ld, 3'b000}, 1'b1, i == dw);
            end
        end
        cyc(3'd5, {4'b0000, ld, 1'b1, ~(st | br), 1'b1}, 1'b1, 1'b1);
    endtask

    initial begin
        do_reset();
        instr(7'b0110011, 0, 0);
        check("first_instret", 32'(instret), 32'd1);
        check("first_cycles", 32'(cycles), 32'd4);
        instr(7'b0000011, 0, 3);
        check("load_instret", 32'(instret), 32'd2);
        check("load_cycles", 32'(cycles), 32'd12);
        instr(7'b0100011, 0, 0);
        instr(7'b1100011, 1, 0);
        instr(7'b1101111, 0, 0);
        instr(7'b1100111, 2, 0);
        instr(7'b0110111, 0, 0);
        instr(7'b0010111, 0, 0);
        instr(7'b0010011, 3, 0);
        instr(7'b0100011, 0, 4);
        hold(5, 3'd7);
        check("dmem_timeout_code", 32'(err_code), 32'd3);

        do_reset();
        instr(7'b0110011, 4, 0);
        hold(10, 3'd7);
        check("imem_timeout_code", 32'(err_code), 32'd2);

        do_reset();
        instr(7'b0000000, 0, 0);
        hold(10, 3'd7);
        check("illegal_code", 32'(err_code), 32'd1);
        check("illegal_instret", 32'(instret), 32'd0);

        do_reset();
        repeat (16) instr(7'b0110011, 0, 0);
        check("wrap_instret", 32'(instret), 32'd0);
        instr(7'b1110011, 0, 0);
        hold(6, 3'd6);
        check("halt_flag", 32'(halted), 32'd1);
        check("halt_cycles", 32'(cycles), 32'd2);

        do_reset();
        instr(7'b0110011, 0, 0);
        abort_at = 2;
        instr(7'b0000011, 0, 5);
        abort_at = -1;
        check("pre_abort_dreq", 32'(dmem_req), 32'd1);
        chk_en = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_dreq", 32'(dmem_req), 32'd0);
        check("abort_state", 32'(state), 32'd0);
        check("abort_instret", 32'(instret), 32'd0);
        check("abort_cycles", 32'(cycles), 32'd0);
        do_reset();
        instr(7'b0110011, 0, 0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got timeout want finish", $time);
        $fatal(1);
    end

endmodule
